// File: rtl/radix2_divider_pkg.sv
// Shared definitions for the iterative radix-2 divider: FSM state encoding and
// counter sizing.
package radix2_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Counter width for an arbitrary operand width; the counter only has to
    // hold WIDTH-1.
    function automatic int div_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/radix2_divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference if it did not go negative.
module restoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] w_r_shift;
    logic [WIDTH:0] w_t;
    logic           w_neg;

    assign w_r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
    assign w_t       = w_r_shift - {1'b0, divisor};
    // A set top bit in r would have been shifted out of r', so the true
    // trial difference is non-negative in that case.
    assign w_neg     = w_t[WIDTH] & ~r[WIDTH];

    assign r_next = w_neg ? w_r_shift : w_t;
    assign q_next = {q[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/radix2_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both the operand and the result side.
module radix2_divider
    import radix2_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
    logic             r_dbz;

    logic             w_accept;
    logic             w_zero;
    logic [WIDTH:0]   w_r_next;
    logic [WIDTH-1:0] w_q_next;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_zero   = (divisor == '0);

    restoring_div_step #(.WIDTH(WIDTH)) u_step (
        .r       (r_rem),
        .q       (r_q),
        .divisor (r_divisor),
        .r_next  (w_r_next),
        .q_next  (w_q_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = w_zero ? DONE : CALC;
            CALC: if (r_cnt == '0) w_state_next = DONE;
            DONE: if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_divisor <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_zero) begin
                            r_q   <= '1;
                            r_rem <= {1'b0, dividend};
                            r_dbz <= 1'b1;
                        end else begin
                            r_divisor <= divisor;
                            r_q       <= dividend;
                            r_rem     <= '0;
                            r_cnt     <= CNT_W'(WIDTH - 1);
                            r_dbz     <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_r_next;
                    r_q   <= w_q_next;
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_q;
    assign remainder   = r_rem[WIDTH-1:0];
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_radix2_divider.sv
// Directed-vector and corner-case bench for radix2_divider at the default width.
module tb_radix2_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    radix2_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one division (out_ready assumed high) and returns the result,
    // the number of cycles after the accept cycle until out_valid, and
    // in_ready in the cycle after the result is taken.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dbz, output int lat, output logic rdy_after);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
        tick();
        rdy_after = in_ready;
    endtask

    initial begin
        logic [W-1:0] q, r, a, b;
        logic         dbz, rdy;
        int           lat;

        vecs[0]  = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,    dbz: 1'b0};
        vecs[1]  = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,    dbz: 1'b0};
        vecs[2]  = '{a: 32'd5,          b: 32'd9,          q: 32'd0,          r: 32'd5,    dbz: 1'b0};
        vecs[3]  = '{a: 32'd1234,       b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd1234, dbz: 1'b1};
        vecs[4]  = '{a: 32'd8,          b: 32'd2,          q: 32'd4,          r: 32'd0,    dbz: 1'b0};
        vecs[5]  = '{a: 32'd1000,       b: 32'd33,         q: 32'd30,         r: 32'd10,   dbz: 1'b0};
        vecs[6]  = '{a: 32'd77,         b: 32'd3,          q: 32'd25,         r: 32'd2,    dbz: 1'b0};
        vecs[7]  = '{a: 32'd7,          b: 32'd7,          q: 32'd1,          r: 32'd0,    dbz: 1'b0};
        vecs[8]  = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,    dbz: 1'b0};
        vecs[9]  = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,    dbz: 1'b0};
        vecs[10] = '{a: 32'h8000_0000,  b: 32'd3,          q: 32'd715827882,  r: 32'd2,    dbz: 1'b0};
        vecs[11] = '{a: 32'd12345678,   b: 32'd1000,       q: 32'd12345,      r: 32'd678,  dbz: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready",  64'(in_ready),    64'd1);
        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_quotient",  64'(quotient),    64'd0);
        check("rst_remainder", 64'(remainder),   64'd0);
        check("rst_dbz",       64'(div_by_zero), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Vectors run back to back; 0xFFFFFFFF/1 -> 5/9 and 1234/0 -> 8/2 are adjacent.
        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].a, vecs[i].b, q, r, dbz, lat, rdy);
            check($sformatf("vec%0d_quotient", i),  64'(q),   64'(vecs[i].q));
            check($sformatf("vec%0d_remainder", i), 64'(r),   64'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i),       64'(dbz), 64'(vecs[i].dbz));
            check($sformatf("vec%0d_latency", i),   64'(lat), vecs[i].dbz ? 64'd0 : 64'(W));
            check($sformatf("vec%0d_ready_after", i), 64'(rdy), 64'd1);
        end

        // Back-pressure: results held, in_ready low, stray operands ignored.
        out_ready = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd33;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("bp_latency", 64'(lat), 64'(W));
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                dividend = 32'd50;
                divisor  = 32'd5;
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check($sformatf("bp_hold%0d_q", k), 64'(quotient), 64'd30);
            check($sformatf("bp_hold%0d_r", k), 64'(remainder), 64'd10);
            check($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
            check($sformatf("bp_hold%0d_out_valid", k), 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready",  64'(in_ready),  64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of a division.
        dividend = 32'd77;
        divisor  = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("mid_busy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready",  64'(in_ready),    64'd1);
        check("midrst_out_valid", 64'(out_valid),   64'd0);
        check("midrst_quotient",  64'(quotient),    64'd0);
        check("midrst_remainder", 64'(remainder),   64'd0);
        check("midrst_dbz",       64'(div_by_zero), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_release_ready", 64'(in_ready),  64'd1);
        check("midrst_no_result",     64'(out_valid), 64'd0);
        run_div(32'd77, 32'd3, q, r, dbz, lat, rdy);
        check("after_rst_q", 64'(q), 64'd25);
        check("after_rst_r", 64'(r), 64'd2);

        // Random regression against the language operators.
        for (int i = 0; i < 1500; i++) begin
            a = $urandom;
            case (i % 4)
                0: begin
                    if (a == '0) a = 32'd1;
                    b = a;
                end
                1: begin
                    a = a & 32'h0000_FFFF;
                    b = $urandom | 32'h0001_0000;
                end
                2: b = 32'($urandom_range(1, 255));
                default: begin
                    b = $urandom;
                    if (b == '0) b = 32'd1;
                end
            endcase
            run_div(a, b, q, r, dbz, lat, rdy);
            check($sformatf("rand%0d_%0h_%0h", i, a, b), {q, r}, {a / b, a % b});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
